imem_loader: RTL and testbench

Boot-time program loader for the single-cycle RISC-V CPU. It receives a length-prefixed byte stream over a valid/ready handshake and assembles little-endian 32-bit words. It writes those words sequentially into instruction memory through a one-cycle write port, then releases the CPU by asserting `cpu_run`. It is the writer side of the instruction-memory interface that the CPU fetch path reads, and it replaces file preloading for hardware bring-up.

---
 rtl/imem_loader.sv | 168 ++++++++++++++++
 tb/tb_imem_loader.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: length-prefixed byte stream -> little-endian 32-bit word writes.
// Optional trailing XOR checksum byte is enabled by defining IMEM_LOADER_CSUM_EN.
module imem_loader #(
    parameter int ADDR_WIDTH = 10,
    parameter int BASE_ADDR  = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [31:0]           wr_data,
    output logic                  cpu_run,
    output logic                  done,
    output logic                  err
);

    typedef enum logic [2:0] {
        ST_LEN0 = 3'd0,
        ST_LEN1 = 3'd1,
        ST_DATA = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
`ifdef IMEM_LOADER_CSUM_EN
        , ST_CSUM = 3'd5
`endif
    } state_t;

    localparam logic [31:0] CAPACITY = 32'd1 << ADDR_WIDTH;

`ifdef IMEM_LOADER_CSUM_EN
    function automatic logic [7:0] csum_next(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction
`endif

    state_t       state_r;
    logic [15:0]  count_r;
    logic [15:0]  word_idx_r;
    logic [1:0]   byte_cnt_r;
    logic [23:0]  partial_r;
`ifdef IMEM_LOADER_CSUM_EN
    logic [7:0]   csum_r;
`endif

    logic         accept_s;
    logic [15:0]  len_s;
    logic         len_bad_s;
    logic         last_word_s;

    assign in_ready    = (state_r != ST_DONE) && (state_r != ST_ERR);
    assign accept_s    = in_valid && in_ready;
    assign len_s       = {in_data, count_r[7:0]};
    assign len_bad_s   = ({16'd0, len_s} > CAPACITY);
    assign last_word_s = (word_idx_r == (count_r - 16'd1));

    // Loader FSM, byte assembly, counters and all registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= ST_LEN0;
            count_r    <= 16'd0;
            word_idx_r <= 16'd0;
            byte_cnt_r <= 2'd0;
            partial_r  <= 24'd0;
`ifdef IMEM_LOADER_CSUM_EN
            csum_r     <= 8'h00;
`endif
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= 32'd0;
            cpu_run    <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            wr_en   <= 1'b0;
            cpu_run <= done;
            case (state_r)
                ST_LEN0: begin
`ifdef IMEM_LOADER_CSUM_EN
                    csum_r <= 8'h00;
`endif
                    if (accept_s) begin
                        count_r <= {8'h00, in_data};
                        state_r <= ST_LEN1;
                    end else begin
                        state_r <= ST_LEN0;
                    end
                end
                ST_LEN1: begin
                    if (accept_s) begin
                        count_r    <= len_s;
                        word_idx_r <= 16'd0;
                        byte_cnt_r <= 2'd0;
                        if (len_bad_s) begin
                            state_r <= ST_ERR;
                            err     <= 1'b1;
                        end else if (len_s != 16'd0) begin
                            state_r <= ST_DATA;
                        end else begin
`ifdef IMEM_LOADER_CSUM_EN
                            state_r <= ST_CSUM;
`else
                            state_r <= ST_DONE;
                            done    <= 1'b1;
`endif
                        end
                    end else begin
                        state_r <= ST_LEN1;
                    end
                end
                ST_DATA: begin
                    if (accept_s) begin
                        byte_cnt_r <= byte_cnt_r + 2'd1;
`ifdef IMEM_LOADER_CSUM_EN
                        csum_r     <= csum_next(csum_r, in_data);
`endif
                        if (byte_cnt_r == 2'd3) begin
                            // b0..b2 were shifted in from the top, so the word is simply {b3, partial}
                            wr_en      <= 1'b1;
                            wr_data    <= {in_data, partial_r};
                            wr_addr    <= ADDR_WIDTH'(32'(BASE_ADDR) + 32'(word_idx_r));
                            word_idx_r <= word_idx_r + 16'd1;
                            partial_r  <= 24'd0;
                            if (last_word_s) begin
`ifdef IMEM_LOADER_CSUM_EN
                                state_r <= ST_CSUM;
`else
                                state_r <= ST_DONE;
                                done    <= 1'b1;
`endif
                            end else begin
                                state_r <= ST_DATA;
                            end
                        end else begin
                            partial_r <= {in_data, partial_r[23:8]};
                        end
                    end else begin
                        state_r <= ST_DATA;
                    end
                end
`ifdef IMEM_LOADER_CSUM_EN
                ST_CSUM: begin
                    if (accept_s) begin
                        if (in_data == csum_r) begin
                            state_r <= ST_DONE;
                            done    <= 1'b1;
                        end else begin
                            state_r <= ST_ERR;
                            err     <= 1'b1;
                        end
                    end else begin
                        state_r <= ST_CSUM;
                    end
                end
`endif
                ST_DONE: state_r <= ST_DONE;
                ST_ERR:  state_r <= ST_ERR;
                default: begin
                    state_r <= ST_ERR;
                    err     <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: a stream model predicts writes and final status; a monitor checks them.
module tb_imem_loader;
    localparam int AW   = 4;
    localparam int BASE = 13;
    localparam int CAP  = 1 << AW;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data = 8'h00;
    logic          in_ready;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [31:0]   wr_data;
    logic          cpu_run;
    logic          done;
    logic          err;

    imem_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .cpu_run(cpu_run), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
        logic          last_done;
    } wr_t;

    wr_t         sbq[$];
    logic [7:0]  stream[$];
    logic [31:0] words[$];
    int          total = 0;
    int          bad = 0;
    bit          exp_done;
    bit          exp_err;
    logic        done_prev = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every write must match the next predicted one; cpu_run must trail done by one cycle
    always @(negedge clk) begin
        if (reset) begin
            chk("cpu_run_lag", {31'd0, cpu_run}, {31'd0, done_prev});
            done_prev = done;
            if (wr_en) begin
                if (sbq.size() == 0) begin
                    chk("spurious_wr_en", 32'd1, 32'd0);
                end else begin
                    wr_t e;
                    e = sbq.pop_front();
                    chk("wr_addr", {{(32-AW){1'b0}}, wr_addr}, {{(32-AW){1'b0}}, e.addr});
                    chk("wr_data", wr_data, e.data);
                    chk("done_at_wr", {31'd0, done}, {31'd0, e.last_done});
                end
            end
        end else begin
            done_prev = 1'b0;
        end
    end

    // Reference model: build the byte stream for a load and predict its writes and outcome
    task automatic build_load(input int cnt, input bit good_csum);
        logic [31:0] c;
        logic [31:0] w;
        logic [7:0]  x;
        wr_t         e;
        c = cnt;
        x = 8'h00;
        stream.delete();
        stream.push_back(c[7:0]);
        stream.push_back(c[15:8]);
        if (cnt > CAP) begin
            exp_done = 1'b0;
            exp_err  = 1'b1;
            return;
        end
        for (int i = 0; i < cnt; i++) begin
            w = (i < words.size()) ? words[i] : $urandom;
            for (int k = 0; k < 4; k++) begin
                stream.push_back(w[8*k +: 8]);
                x = x ^ w[8*k +: 8];
            end
            e.addr = AW'((BASE + i) % CAP);
            e.data = w;
`ifdef IMEM_LOADER_CSUM_EN
            e.last_done = 1'b0;
`else
            e.last_done = (i == cnt - 1);
`endif
            sbq.push_back(e);
        end
`ifdef IMEM_LOADER_CSUM_EN
        stream.push_back(good_csum ? x : (x ^ 8'h5A));
        exp_done = good_csum;
        exp_err  = !good_csum;
`else
        exp_done = 1'b1;
        exp_err  = 1'b0;
`endif
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        in_valid = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
        chk("rst_wr_addr", {{(32-AW){1'b0}}, wr_addr}, 32'd0);
        chk("rst_wr_data", wr_data, 32'd0);
        chk("rst_cpu_run", {31'd0, cpu_run}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
    endtask

    // Drive the stream; called at posedge+1. stall_idx gets stall_len idle cycles before it.
    task automatic send(input int stall_idx, input int stall_len, input bit rnd, input bit partial);
        int n;
        int st;
        int wt;
        n = stream.size();
        for (int i = 0; i < n; i++) begin
            st = (i == stall_idx) ? stall_len : ((rnd && $urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
            in_valid = 1'b0;
            repeat (st) begin @(posedge clk); #1; end
            in_valid = 1'b1;
            in_data  = stream[i];
            wt = 0;
            while (!in_ready && wt < 50) begin @(posedge clk); #1; wt++; end
            if (wt == 50) begin
                chk("ready_timeout", 32'd0, 32'd1);
                in_valid = 1'b0;
                return;
            end
            if (i == n - 1 && !partial) begin
                @(negedge clk);
                chk("done_early", {31'd0, done}, 32'd0);
                chk("err_early", {31'd0, err}, 32'd0);
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (partial) return;
        @(negedge clk);
        chk("done_latency", {31'd0, done}, {31'd0, exp_done});
        chk("err_latency", {31'd0, err}, {31'd0, exp_err});
        chk("cpu_run_not_yet", {31'd0, cpu_run}, 32'd0);
        repeat (3) @(negedge clk);
        chk("done_final", {31'd0, done}, {31'd0, exp_done});
        chk("err_final", {31'd0, err}, {31'd0, exp_err});
        chk("cpu_run_final", {31'd0, cpu_run}, {31'd0, exp_done});
        chk("in_ready_final", {31'd0, in_ready}, 32'd0);
        chk("sb_drained", sbq.size(), 32'd0);
    endtask

    initial begin
        do_reset();
        words = '{32'h00000013, 32'h00100093};
        build_load(2, 1'b1);
        send(-1, 0, 1'b0, 1'b0);

        do_reset();
        build_load(2, 1'b1);
        send(4, 5, 1'b0, 1'b0);

        do_reset();
        words.delete();
        build_load(32'h0401, 1'b1);
        send(-1, 0, 1'b0, 1'b0);

        do_reset();
        build_load(0, 1'b1);
        send(-1, 0, 1'b0, 1'b0);

        do_reset();
        build_load(CAP, 1'b1);
        send(-1, 0, 1'b1, 1'b0);

        do_reset();
        build_load(CAP + 1, 1'b1);
        send(-1, 0, 1'b0, 1'b0);

        do_reset();
        words = '{32'h00000013};
        build_load(1, 1'b1);
        send(-1, 0, 1'b0, 1'b0);

        do_reset();
        build_load(1, 1'b0);
        send(-1, 0, 1'b0, 1'b0);

        do_reset();
        stream = '{8'h01, 8'h00, 8'h44, 8'h33, 8'h22};
        send(-1, 0, 1'b0, 1'b1);
        do_reset();
        words = '{32'hDEADBEEF};
        build_load(1, 1'b1);
        send(-1, 0, 1'b0, 1'b0);

        words.delete();
        for (int r = 0; r < 10; r++) begin
            do_reset();
            build_load($urandom_range(0, CAP + 1), ($urandom_range(0, 2) != 0));
            send(-1, 0, 1'b1, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
